// File: rtl/ram_load_ctrl_pkg.sv
// Shared types for the instruction RAM load sequencer.
// Contents: mode_t, state_t, DELIM_DEFAULT, decode_mode().
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'd0,
        MODE_DEBUG = 2'd1,
        MODE_RUN   = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        LOAD_DATA,
        LOAD_DELIM,
        DEBUG,
        RUN
    } state_t;

    localparam logic [7:0] DELIM_DEFAULT = 8'h24;

    // Selector value 3 behaves as RUN.
    function automatic mode_t decode_mode(input logic [1:0] sel);
        mode_t m;
        unique case (sel)
            2'd0:    m = MODE_LOAD;
            2'd1:    m = MODE_DEBUG;
            default: m = MODE_RUN;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ram_load_ctrl_if.sv
// RAM port bundle between the load sequencer and the storage array.
// master: drives ram_we/ram_addr/ram_wdata, reads ram_rdata; slave: the RAM.
interface ram_load_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport master (
        output ram_we,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_load_ctrl_step_sync.sv
// Debug button synchronizer (2 flops) plus rising-edge detector.
// Ports: clk, rst (async active-low), btn (raw), step (one-cycle pulse).
module step_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic step
);
    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign step = s2_q & ~s3_q;
endmodule

// File: rtl/ram_load_ctrl.sv
// Instruction RAM sequencer: UART "data $" load, debug stepping, CPU fetch.
// Ports: clk, rst (async active-low), mode_sel, rx_data/rx_valid, step_btn,
// cpu_addr, ram (master RAM bundle), data_out, prog_len, frame_err, overflow.
// Define RAM_STEP_SYNC_EN to synchronize and edge-detect step_btn.
module ram_load_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int              ADDR_WIDTH  = 8,
    parameter int              DATA_WIDTH  = 8,
    parameter int              MAX_ADDRESS = 255,
    parameter logic [DATA_WIDTH-1:0] DELIM = DATA_WIDTH'(DELIM_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode_sel,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  step_btn,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    ram_load_ctrl_if.master       ram,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  frame_err,
    output logic                  overflow
);
    localparam logic [ADDR_WIDTH:0] MAX_PTR = (ADDR_WIDTH+1)'(MAX_ADDRESS);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] DBG_ONE = ADDR_WIDTH'(1);

    state_t state_q;
    state_t state_d;
    mode_t  mode;

    // wr_ptr is one bit wider than the address so it saturates past MAX.
    logic [ADDR_WIDTH:0]   wr_ptr_q;
    logic [ADDR_WIDTH-1:0] dbg_ptr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] pend_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  ferr_q;
    logic                  ovf_q;
    logic                  step;

    logic in_load;
    logic load_entry;
    logic dbg_entry;
    logic rx_delim;
    logic can_step;

    assign mode       = decode_mode(mode_sel);
    assign in_load    = (state_q == LOAD_DATA) || (state_q == LOAD_DELIM);
    assign load_entry = (mode == MODE_LOAD) && !in_load;
    assign dbg_entry  = (mode == MODE_DEBUG) && (state_q != DEBUG);
    assign rx_delim   = rx_valid && (rx_data == DELIM);
    assign can_step   = ({1'b0, dbg_ptr_q} + PTR_ONE) < wr_ptr_q;

`ifdef RAM_STEP_SYNC_EN
    step_sync u_step_sync (
        .clk  (clk),
        .rst  (rst),
        .btn  (step_btn),
        .step (step)
    );
`else
    assign step = step_btn;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= LOAD_DATA;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            mode == MODE_LOAD: begin
                if (!in_load)
                    state_d = LOAD_DATA;
                else if (state_q == LOAD_DATA && rx_valid)
                    state_d = LOAD_DELIM;
                else if (state_q == LOAD_DELIM && rx_delim)
                    state_d = LOAD_DATA;
            end
            mode == MODE_DEBUG: state_d = DEBUG;
            default:            state_d = RUN;
        endcase
    end

    // Bytes are consumed whenever the current state is a LOAD state,
    // so a strobe on the edge that leaves LOAD still completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            dbg_ptr_q <= '0;
            addr_q    <= '0;
            pend_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (load_entry) begin
                wr_ptr_q <= '0;
                pend_q   <= '0;
                ferr_q   <= 1'b0;
                ovf_q    <= 1'b0;
            end else if (in_load && rx_valid) begin
                if (state_q == LOAD_DATA) begin
                    pend_q <= rx_data;
                end else if (rx_delim) begin
                    if (wr_ptr_q <= MAX_PTR) begin
                        we_q     <= 1'b1;
                        addr_q   <= wr_ptr_q[ADDR_WIDTH-1:0];
                        wdata_q  <= pend_q;
                        wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    end else begin
                        ovf_q <= 1'b1;
                    end
                end else begin
                    pend_q <= rx_data;
                    ferr_q <= 1'b1;
                end
            end
            if (dbg_entry)
                dbg_ptr_q <= '0;
            else if (state_q == DEBUG && step && can_step)
                dbg_ptr_q <= dbg_ptr_q + DBG_ONE;
        end
    end

    // A write issued on the edge that left LOAD keeps its own address.
    always_comb begin
        ram.ram_addr = addr_q;
        data_out     = '0;
        unique case (1'b1)
            state_q == DEBUG: begin
                if (!we_q) ram.ram_addr = dbg_ptr_q;
                if (wr_ptr_q != '0) data_out = ram.ram_rdata;
            end
            state_q == RUN: begin
                if (!we_q) ram.ram_addr = cpu_addr;
                data_out = ram.ram_rdata;
            end
            default: ;
        endcase
    end

    assign ram.ram_we    = we_q;
    assign ram.ram_wdata = wdata_q;
    assign prog_len      = wr_ptr_q;
    assign frame_err     = ferr_q;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_ram_load_ctrl.sv
// Directed bench for ram_load_ctrl with a write scoreboard.
// Instance a: full-size RAM; instance b: MAX_ADDRESS=3 for overflow.
module tb_ram_load_ctrl;
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk;
    logic       rst;
    logic [1:0] mode_a;
    logic [7:0] rxd_a;
    logic       rxv_a;
    logic       step_a;
    logic [7:0] cpu_a;
    logic [7:0] dout_a;
    logic [8:0] plen_a;
    logic       ferr_a;
    logic       ovf_a;

    logic [1:0] mode_b;
    logic [7:0] rxd_b;
    logic       rxv_b;
    logic       step_b;
    logic [7:0] cpu_b;
    logic [7:0] dout_b;
    logic [8:0] plen_b;
    logic       ferr_b;
    logic       ovf_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    wr_t qa[$];
    wr_t qb[$];

    int n_cmp = 0;
    int n_err = 0;
    logic last_we_a;
    logic last_we_b;

    ram_load_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus_a ();
    ram_load_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus_b ();

    ram_load_ctrl #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_ADDRESS(255), .DELIM(8'h24)
    ) dut_a (
        .clk(clk), .rst(rst), .mode_sel(mode_a),
        .rx_data(rxd_a), .rx_valid(rxv_a), .step_btn(step_a),
        .cpu_addr(cpu_a), .ram(bus_a.master), .data_out(dout_a),
        .prog_len(plen_a), .frame_err(ferr_a), .overflow(ovf_a)
    );

    ram_load_ctrl #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_ADDRESS(3), .DELIM(8'h24)
    ) dut_b (
        .clk(clk), .rst(rst), .mode_sel(mode_b),
        .rx_data(rxd_b), .rx_valid(rxv_b), .step_btn(step_b),
        .cpu_addr(cpu_b), .ram(bus_b.master), .data_out(dout_b),
        .prog_len(plen_b), .frame_err(ferr_b), .overflow(ovf_b)
    );

    assign bus_a.ram_rdata = mem_a[bus_a.ram_addr];
    assign bus_b.ram_rdata = mem_b[bus_b.ram_addr];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (bus_a.ram_we === 1'b1) mem_a[bus_a.ram_addr] <= bus_a.ram_wdata;
        if (bus_b.ram_we === 1'b1) mem_b[bus_b.ram_addr] <= bus_b.ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus_a.ram_we === 1'b1) begin
            if (qa.size() == 0) begin
                chk("wr_a_unexpected", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("wr_a_addr", 32'(bus_a.ram_addr), 32'(e.addr));
                chk("wr_a_data", 32'(bus_a.ram_wdata), 32'(e.data));
            end
        end
        if (bus_b.ram_we === 1'b1) begin
            if (qb.size() == 0) begin
                chk("wr_b_unexpected", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("wr_b_addr", 32'(bus_b.ram_addr), 32'(e.addr));
                chk("wr_b_data", 32'(bus_b.ram_wdata), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        rxv_a = 1'b1;
        rxd_a = b;
        tick();
        last_we_a = bus_a.ram_we;
        rxv_a = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_b(input logic [7:0] b);
        rxv_b = 1'b1;
        rxd_b = b;
        tick();
        last_we_b = bus_b.ram_we;
        rxv_b = 1'b0;
        repeat (3) tick();
    endtask

    task automatic step_once();
        step_a = 1'b1;
        tick();
        step_a = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        rst = 1'b0;
        mode_a = 2'd0; rxd_a = 8'h00; rxv_a = 1'b0;
        step_a = 1'b0; cpu_a = 8'h00;
        mode_b = 2'd0; rxd_b = 8'h00; rxv_b = 1'b0;
        step_b = 1'b0; cpu_b = 8'h00;
        last_we_a = 1'b0;
        last_we_b = 1'b0;

        #25;
        chk("rst_we", 32'(bus_a.ram_we), 32'd0);
        chk("rst_addr", 32'(bus_a.ram_addr), 32'd0);
        chk("rst_wdata", 32'(bus_a.ram_wdata), 32'd0);
        chk("rst_dout", 32'(dout_a), 32'd0);
        chk("rst_plen", 32'(plen_a), 32'd0);
        chk("rst_ferr", 32'(ferr_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Overflow on the small instance
        for (int i = 0; i < 4; i++) begin
            send_b(8'h10 + 8'(i));
            qb.push_back('{addr: 8'(i), data: 8'h10 + 8'(i)});
            send_b(8'h24);
        end
        chk("ovf_b_before", 32'(ovf_b), 32'd0);
        chk("plen_b_4", 32'(plen_b), 32'd4);
        send_b(8'h14);
        send_b(8'h24);
        chk("ovf_b_we", 32'(last_we_b), 32'd0);
        chk("ovf_b_set", 32'(ovf_b), 32'd1);
        chk("ovf_b_plen", 32'(plen_b), 32'd4);

        // Load four bytes
        for (int i = 0; i < 4; i++) begin
            send_a(8'h4A + 8'(i));
            qa.push_back('{addr: 8'(i), data: 8'h4A + 8'(i)});
            send_a(8'h24);
            chk("load_we_latency", 32'(last_we_a), 32'd1);
        end
        chk("load_plen", 32'(plen_a), 32'd4);
        chk("load_ferr", 32'(ferr_a), 32'd0);
        chk("load_dout", 32'(dout_a), 32'd0);

        // Debug stepping
        mode_a = 2'd1;
        tick();
        chk("dbg_first", 32'(dout_a), 32'h4A);
        for (int i = 1; i < 4; i++) begin
            step_once();
            chk("dbg_step", 32'(dout_a), 32'h4A + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            step_once();
            chk("dbg_hold_end", 32'(dout_a), 32'h4D);
        end
        mode_a = 2'd2;
        tick();
        mode_a = 2'd1;
        tick();
        chk("dbg_reentry", 32'(dout_a), 32'h4A);
        step_a = 1'b1;
        repeat (10) tick();
        step_a = 1'b0;
        repeat (4) tick();
`ifdef RAM_STEP_SYNC_EN
        chk("dbg_held_btn", 32'(dout_a), 32'h4B);
`else
        chk("dbg_held_btn", 32'(dout_a), 32'h4D);
`endif

        // RUN fetch
        mode_a = 2'd2;
        tick();
        for (int i = 0; i < 4; i++) begin
            cpu_a = 8'(i);
            #1;
            chk("run_fetch", 32'(dout_a), 32'h4A + 32'(i));
        end
        mode_a = 2'd3;
        cpu_a = 8'd2;
        tick();
        chk("run_mode3", 32'(dout_a), 32'h4C);

        // LOAD re-entry clears
        mode_a = 2'd0;
        tick();
        chk("reload_plen", 32'(plen_a), 32'd0);
        chk("reload_dout", 32'(dout_a), 32'd0);

        // Framing error, then delimiter value as data
        send_a(8'h4A);
        send_a(8'h4B);
        chk("ferr_set", 32'(ferr_a), 32'd1);
        qa.push_back('{addr: 8'd0, data: 8'h4B});
        send_a(8'h24);
        chk("ferr_plen", 32'(plen_a), 32'd1);
        send_a(8'h24);
        qa.push_back('{addr: 8'd1, data: 8'h24});
        send_a(8'h24);
        chk("delim_as_data", 32'(plen_a), 32'd2);
        chk("ferr_sticky", 32'(ferr_a), 32'd1);

        // Delimiter on the edge that leaves LOAD still commits
        send_a(8'h77);
        qa.push_back('{addr: 8'd2, data: 8'h77});
        rxv_a = 1'b1;
        rxd_a = 8'h24;
        mode_a = 2'd1;
        tick();
        rxv_a = 1'b0;
        chk("modechg_commit", 32'(plen_a), 32'd3);
        tick();

        // Byte during DEBUG->LOAD change is ignored
        rxv_a = 1'b1;
        rxd_a = 8'h55;
        mode_a = 2'd0;
        tick();
        rxv_a = 1'b0;
        chk("reentry_plen", 32'(plen_a), 32'd0);
        chk("reentry_ferr", 32'(ferr_a), 32'd0);
        send_a(8'h24);
        chk("ignored_byte_nowr", 32'(plen_a), 32'd0);

        // Pending byte discarded when leaving LOAD
        mode_a = 2'd2;
        tick();
        mode_a = 2'd0;
        tick();
        send_a(8'h24);
        chk("discard_pending", 32'(plen_a), 32'd0);

        // Reset between data byte and delimiter
        send_a(8'h4B);
        chk("pre_rst_ferr", 32'(ferr_a), 32'd1);
        rst = 1'b0;
        #2;
        chk("midrst_ferr", 32'(ferr_a), 32'd0);
        chk("midrst_plen", 32'(plen_a), 32'd0);
        chk("midrst_we", 32'(bus_a.ram_we), 32'd0);
        chk("midrst_addr", 32'(bus_a.ram_addr), 32'd0);
        chk("midrst_dout", 32'(dout_a), 32'd0);
        chk("midrst_ovf_b", 32'(ovf_b), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        send_a(8'h24);
        chk("post_rst_nowr", 32'(last_we_a), 32'd0);
        chk("post_rst_plen", 32'(plen_a), 32'd0);

        repeat (3) tick();
        chk("sb_a_drained", 32'(qa.size()), 32'd0);
        chk("sb_b_drained", 32'(qb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_load_ctrl.md
# ram_load_ctrl

Sequencer for the intermediary instruction RAM. Receives UART bytes in `data $ data $ …` framing and writes them to consecutive RAM addresses. Steps through the stored program on a debug button, then hands the RAM address port to the CPU for random-access fetch. Owns the RAM's write enable, address mux and program-length bookkeeping, so the RAM itself stays a plain storage array.

## Interface
- `ADDR_WIDTH`, 8, RAM address width
- `DATA_WIDTH`, 8, byte width
- `MAX_ADDRESS`, 255, highest writable address
- `DELIM`, 8'h24, frame delimiter byte ('$')

- `clk`  in  1  system clock, 50 MHz
- `rst`  in  1  reset; asynchronous, active-low
- `mode_sel`  in  2  0 = LOAD, 1 = DEBUG, 2 = RUN, 3 = treated as RUN
- `rx_data`  in  DATA_WIDTH  byte from UART receiver
- `rx_valid`  in  1  one-cycle strobe per received byte
- `step_btn`  in  1  debug step button
- `cpu_addr`  in  ADDR_WIDTH  fetch address in RUN
- `ram_rdata`  in  DATA_WIDTH  RAM read data (combinational read)
- `ram_we`  out  1  RAM write enable, one-cycle pulse
- `ram_addr`  out  ADDR_WIDTH  RAM address
- `ram_wdata`  out  DATA_WIDTH  RAM write data
- `data_out`  out  DATA_WIDTH  byte presented to the display/CPU
- `prog_len`  out  ADDR_WIDTH+1  committed byte count
- `frame_err`  out  1  sticky: framing violation seen
- `overflow`  out  1  sticky: commit attempted past MAX_ADDRESS

## Operation
- **States:** `LOAD_DATA`, `LOAD_DELIM`, `DEBUG`, `RUN`. Reset enters `LOAD_DATA`.
- **Mode changes:**
  - `mode_sel` is sampled every cycle and a change takes effect on the next edge.
  - Entering LOAD from another mode clears `wr_ptr`, `prog_len`, `frame_err`, `overflow` and any pending byte.
  - Entering DEBUG sets `dbg_ptr` = 0.
- **`LOAD_DATA`:** any byte with `rx_valid` is latched as pending (a value of 0x24 is accepted as data). Next state is `LOAD_DELIM`.
- **`LOAD_DELIM`:**
  - `rx_valid` with `DELIM` commits the pending byte and returns to `LOAD_DATA`.
  - `rx_valid` with any other byte replaces the pending byte and sets `frame_err`; state holds.
- **Commit:**
  - If `wr_ptr` ≤ MAX_ADDRESS: `ram_we`=1, `ram_addr`=`wr_ptr`, `ram_wdata`=pending. Then `wr_ptr`++ and `prog_len`++.
  - Otherwise the write is dropped and `overflow` is set.
  - `wr_ptr` never wraps.
- **Leaving LOAD** with a byte pending discards it; no write occurs.
- **`DEBUG`:**
  - `ram_addr`=`dbg_ptr`.
  - On each step event, `dbg_ptr`++ if `dbg_ptr` < `prog_len`−1; otherwise it holds on the last byte.
  - If `prog_len`=0, `dbg_ptr` stays 0 and `data_out`=0.
- **`RUN`:** `ram_addr`=`cpu_addr` (combinational pass-through). Addresses ≥ `prog_len` are not checked.
- **`data_out`:** `ram_rdata` in DEBUG/RUN; 0 in LOAD.

## Timing
- **Reset values:** `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `data_out`=0, `prog_len`=0, `frame_err`=0, `overflow`=0, `dbg_ptr`=0, `wr_ptr`=0.
- **Write latency:** `ram_we` is registered and asserts the cycle after the delimiter strobe edge. `prog_len` updates on that same edge.
- **Back-to-back `rx_valid`:** strobes on consecutive cycles are legal. Every strobe is consumed.
- **`rx_valid` coinciding with a mode change:** the byte is processed under the old mode only if the old mode is LOAD.
- **Step:** `dbg_ptr` updates one edge after the step event. `data_out` follows combinationally from `ram_rdata`.
- **Reset mid-load:** all state clears immediately (asynchronous). Partially loaded RAM contents remain but `prog_len`=0.

## Configuration
- **`RAM_STEP_SYNC_EN` defined:**
  - `step_btn` passes through a 2-flop synchronizer and a rising-edge detector.
  - Holding the button produces exactly one step. Latency from raw edge to `dbg_ptr` change is 3 edges.
- **`RAM_STEP_SYNC_EN` not defined:**
  - `step_btn` is used directly as a synchronous step event.
  - Each cycle it is high is one step (for a caller that already provides a clean pulse).

## Structure
- **Package `ram_ctrl_pkg`:** `mode_t` enum (LOAD/DEBUG/RUN), `state_t` enum (four states), `DELIM_DEFAULT`=8'h24.
- **Sub-module `step_sync`:** synchronizer plus edge detector. Instantiated only under `RAM_STEP_SYNC_EN`.

## Test plan
- **Load four bytes:** bytes 4A,24,4B,24,4C,24,4D,24 in LOAD, 80 ns apart → four `ram_we` pulses at addr 0–3, data 4A–4D, `prog_len`=4, `frame_err`=0.
- **Framing error:** bytes 4A,4B,24 → single write of 4B at addr 0, `frame_err`=1. Byte 24,24 from `LOAD_DATA` → 24 written as data.
- **Debug stepping past the end:** DEBUG after the first test: `data_out`=4A. Three steps → 4D. Four more steps → holds 4D. Held button with `RAM_STEP_SYNC_EN` → one step only.
- **RUN fetch:** `cpu_addr`=0..3 → `data_out`=4A,4B,4C,4D in the same cycle.
- **Overflow:** MAX_ADDRESS=3, five frames → four writes, fifth dropped, `overflow`=1, `prog_len`=4.
- **Reset and mode-change clears:**
  - `rst` low between data byte and delimiter → no write, all outputs 0.
  - LOAD re-entry → `prog_len`=0 and flags cleared.
